// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and helpers for the PC / instruction-fetch sequencer.
package pc_fetch_unit_pkg;

    localparam logic [31:0] BOOT_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2,
        SEL_JR  = 2'd3
    } sel_e;

    // J-type target: keep the 256 MB region of the delay-slot PC.
    function automatic logic [31:0] jmp_target(input logic [31:0] base,
                                               input logic [25:0] index);
        return {base[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jr > jmp > taken branch > sequential, plus target math.
module pc_next_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] seq_base,
    input  logic        br_taken,
    input  logic [31:0] br_base_pc,
    input  logic [31:0] br_offset,
    input  logic        jmp,
    input  logic [25:0] jmp_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        redirect,
    output logic [31:0] next_pc,
    output logic        jr_misaligned
);

    sel_e sel;

    always_comb begin
        sel = SEL_SEQ;
        if (jr) begin
            sel = SEL_JR;
        end else if (jmp) begin
            sel = SEL_JMP;
        end else if (br_taken) begin
            sel = SEL_BR;
        end
    end

    // Both adders wrap modulo 2^32 by construction.
    always_comb begin
        next_pc = seq_base + 32'd4;
        unique case (sel)
            SEL_JR:  next_pc = {jr_target[31:2], 2'b00};
            SEL_JMP: next_pc = jmp_target(br_base_pc, jmp_index);
            SEL_BR:  next_pc = br_base_pc + br_offset;
            default: next_pc = seq_base + 32'd4;
        endcase
    end

    assign redirect      = (sel != SEL_SEQ);
    assign jr_misaligned = jr && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: req/ack to instruction memory, redirect
// handling with a pending target while a request is outstanding.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = BOOT_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_base_pc,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              jmp,
    input  logic [25:0]       jmp_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              valid_out,
    output logic              align_err
);

    state_e            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              valid_reg, valid_next;
    logic              align_reg, align_next;
    logic              pend_valid_reg, pend_valid_next;
    logic [ADDR_W-1:0] pend_addr_reg, pend_addr_next;

    logic              sel_redirect;
    logic [ADDR_W-1:0] sel_pc;
    logic              sel_misaligned;
    logic              redirect_now;

    pc_next_sel u_next_sel (
        .seq_base      (addr_reg),
        .br_taken      (br_taken),
        .br_base_pc    (br_base_pc),
        .br_offset     (br_offset),
        .jmp           (jmp),
        .jmp_index     (jmp_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .redirect      (sel_redirect),
        .next_pc       (sel_pc),
        .jr_misaligned (sel_misaligned)
    );

    // Redirect inputs are meaningless until the first fetch has been issued.
    assign redirect_now = sel_redirect && (state_reg != ST_BOOT);

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        pc_next         = pc_reg;
        valid_next      = valid_reg;
        pend_valid_next = pend_valid_reg;
        pend_addr_next  = pend_addr_reg;
        align_next      = sel_misaligned && (state_reg != ST_BOOT);

        unique case (state_reg)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    // A fresh redirect beats an older pending one; either drops this fetch.
                    pc_next         = addr_reg;
                    valid_next      = !(redirect_now || pend_valid_reg);
                    addr_next       = (pend_valid_reg && !redirect_now) ? pend_addr_reg : sel_pc;
                    pend_valid_next = 1'b0;
                    if (stall) begin
                        state_next = ST_HOLD;
                    end
                end else if (redirect_now) begin
                    pend_valid_next = 1'b1;
                    pend_addr_next  = sel_pc;
                end
            end
            ST_HOLD: begin
                if (redirect_now) begin
                    pend_valid_next = 1'b1;
                    pend_addr_next  = sel_pc;
                    valid_next      = 1'b0;
                end
                if (!stall) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_BOOT;
            addr_reg       <= RESET_PC;
            pc_reg         <= RESET_PC;
            valid_reg      <= 1'b0;
            align_reg      <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= RESET_PC;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            pc_reg         <= pc_next;
            valid_reg      <= valid_next;
            align_reg      <= align_next;
            pend_valid_reg <= pend_valid_next;
            pend_addr_reg  <= pend_addr_next;
        end
    end

    assign imem_req  = (state_reg == ST_FETCH);
    assign imem_addr = addr_reg;
    assign pc_out    = pc_reg;
    assign pc_plus4  = pc_reg + ADDR_W'(4);
    assign valid_out = valid_reg;
    assign align_err = align_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected fetches, a
// monitor checks every req/ack handshake and the delivery that follows it.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_base_pc;
    logic [31:0] br_offset;
    logic        jmp;
    logic [25:0] jmp_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        valid_out;
    logic        align_err;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_base_pc (br_base_pc),
        .br_offset  (br_offset),
        .jmp        (jmp),
        .jmp_index  (jmp_index),
        .jr         (jr),
        .jr_target  (jr_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .valid_out  (valid_out),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        deliver;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect one acked fetch at address a; deliver says whether decode gets it.
    task automatic hs(input logic [31:0] a, input logic d);
        exp_t e;
        e.addr    = a;
        e.deliver = d;
        exp_q.push_back(e);
        step();
    endtask

    // Monitor: compare the handshake address, then the delivery one edge later.
    initial begin : monitor
        exp_t cur;
        bit   pend_chk;
        pend_chk = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (pend_chk) begin
                check("valid_out", {31'd0, valid_out}, {31'd0, cur.deliver});
                check("pc_out", pc_out, cur.addr);
                check("pc_plus4", pc_plus4, cur.addr + 32'd4);
                pend_chk = 1'b0;
            end
            if (rst_n && imem_req && imem_ack) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_fetch: got %08h expected none", imem_addr);
                end else begin
                    cur = exp_q.pop_front();
                    check("imem_addr", imem_addr, cur.addr);
                    pend_chk = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        rst_n      = 1'b0;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_base_pc = 32'd0;
        br_offset  = 32'd0;
        jmp        = 1'b0;
        jmp_index  = 26'd0;
        jr         = 1'b0;
        jr_target  = 32'd0;
        imem_ack   = 1'b0;
        step();
        step();

        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_pc4", pc_plus4, 32'h4);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_align", {31'd0, align_err}, 32'd0);

        // Sequential fetch with ack every cycle
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        step();
        hs(32'h0, 1'b1);
        hs(32'h4, 1'b1);
        hs(32'h8, 1'b1);
        hs(32'hC, 1'b1);

        // Taken branch with backward offset in the ack cycle
        br_taken   = 1'b1;
        br_base_pc = 32'h0000_0100;
        br_offset  = 32'hFFFF_FFF0;
        hs(32'h10, 1'b0);
        br_taken   = 1'b0;

        // Jump while the request at 0xF0 waits three cycles for ack
        imem_ack   = 1'b0;
        jmp        = 1'b1;
        jmp_index  = 26'h0000040;
        br_base_pc = 32'h4000_0010;
        step();
        jmp = 1'b0;
        check("stable_addr_1", imem_addr, 32'hF0);
        step();
        check("stable_addr_2", imem_addr, 32'hF0);
        step();
        check("stable_addr_3", imem_addr, 32'hF0);
        imem_ack = 1'b1;
        hs(32'hF0, 1'b0);

        // Misaligned jr target
        jr        = 1'b1;
        jr_target = 32'h0000_2003;
        hs(32'h4000_0100, 1'b0);
        jr = 1'b0;
        check("align_pulse", {31'd0, align_err}, 32'd1);
        jmp        = 1'b1;
        jmp_index  = 26'h0000008;
        br_base_pc = 32'h0000_0000;
        hs(32'h2000, 1'b0);
        jmp = 1'b0;
        check("align_clear", {31'd0, align_err}, 32'd0);

        // Stall on the ack at 0x20
        stall = 1'b1;
        hs(32'h20, 1'b1);
        check("hold_req", {31'd0, imem_req}, 32'd0);
        step();
        check("hold_req_2", {31'd0, imem_req}, 32'd0);
        check("hold_pc", pc_out, 32'h20);
        check("hold_valid", {31'd0, valid_out}, 32'd1);
        stall = 1'b0;
        step();
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h24);
        hs(32'h24, 1'b1);
        hs(32'h28, 1'b1);

        // All three redirects together: jr wins; then sequential wrap at the top
        jr         = 1'b1;
        jr_target  = 32'hFFFF_FFF8;
        jmp        = 1'b1;
        jmp_index  = 26'h3FFFFFF;
        br_taken   = 1'b1;
        br_offset  = 32'h0000_0004;
        hs(32'h2C, 1'b0);
        jr       = 1'b0;
        jmp      = 1'b0;
        br_taken = 1'b0;
        check("align_quiet", {31'd0, align_err}, 32'd0);
        hs(32'hFFFF_FFF8, 1'b1);
        hs(32'hFFFF_FFFC, 1'b1);
        jmp        = 1'b1;
        jmp_index  = 26'h0000020;
        br_base_pc = 32'h0000_0000;
        hs(32'h0, 1'b0);
        jmp = 1'b0;

        // Asynchronous reset with a request outstanding at 0x80
        imem_ack = 1'b0;
        step();
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        check("pre_rst_addr", imem_addr, 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req", {31'd0, imem_req}, 32'd0);
        check("async_addr", imem_addr, 32'h0);
        check("async_valid", {31'd0, valid_out}, 32'd0);
        check("async_pc", pc_out, 32'h0);
        imem_ack = 1'b1;
        step();
        step();
        check("rst_hold_req", {31'd0, imem_req}, 32'd0);
        check("rst_hold_addr", imem_addr, 32'h0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
